// File: rtl/pwm_fade_controller_if.sv
// Snooped deserializer write stream: one-cycle transaction strobe plus
// address and data for the fade controller's configuration registers.
interface pwm_fade_controller_if;
  logic       valid;
  logic       read_write;
  logic [6:0] addr;
  logic [7:0] data;

  modport master (output valid, output read_write, output addr, output data);
  modport slave  (input  valid, input  read_write, input  addr, input  data);
endinterface

// File: rtl/pwm_fade_controller.sv
// Duty-cycle sequencer: ramps an 8-bit duty value toward TARGET at a
// programmable rate, either settling once or breathing between 0 and TARGET.
module pwm_fade_controller #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pwm_fade_controller_if.slave  bus,
  output logic [7:0]            duty_out,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;

  localparam logic [6:0] ADDR_DUTY   = 7'h04;
  localparam logic [6:0] ADDR_TARGET = 7'h05;
  localparam logic [6:0] ADDR_STEP   = 7'h06;
  localparam logic [6:0] ADDR_DIV    = 7'h07;
  localparam logic [6:0] ADDR_CTRL   = 7'h08;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} - {1'b0, b};
    return s[8] ? 8'h00 : s[7:0];
  endfunction

  state_t                  state_q, state_d;
  logic [7:0]              duty_q, duty_d;
  logic                    mode_q, mode_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [PRESCALE_W-1:0]   tick_q, tick_d;
  logic [7:0]              div_cnt_q, div_cnt_d;
  logic [7:0]              target_q, step_q, div_q;

  logic                    wr_s, ctrl_wr_s, start_s, abort_s, step_ev_s;
  logic [7:0]              step_eff_s, up_sum_s, dn_diff_s, settle_duty_s;

  assign wr_s       = bus.valid && bus.read_write;
  assign ctrl_wr_s  = wr_s && (bus.addr == ADDR_CTRL);
  assign start_s    = ctrl_wr_s && bus.data[0];
  assign abort_s    = ctrl_wr_s && bus.data[2];
  assign step_eff_s = (step_q == 8'h00) ? 8'h01 : step_q;
  assign up_sum_s   = sat_add(duty_q, step_eff_s);
  assign dn_diff_s  = sat_sub(duty_q, step_eff_s);
  assign step_ev_s  = (state_q != IDLE) && (&tick_q) && (div_cnt_q == div_q);

  // Non-breathe step: move toward the live TARGET, clamping so it is never overshot
  assign settle_duty_s = (duty_q < target_q) ? ((up_sum_s > target_q) ? target_q : up_sum_s) :
                         (duty_q > target_q) ? ((dn_diff_s < target_q) ? target_q : dn_diff_s) :
                         duty_q;

  // Configuration register capture from the snooped write stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= 8'h00;
      step_q   <= 8'h01;
      div_q    <= 8'h00;
    end else if (wr_s) begin
      if (bus.addr == ADDR_TARGET) target_q <= bus.data;
      else if (bus.addr == ADDR_STEP) step_q <= bus.data;
      else if (bus.addr == ADDR_DIV) div_q <= bus.data;
      else target_q <= target_q;
    end else begin
      target_q <= target_q;
    end
  end

  // Ramp sequencer next-state, prescaler and duty update
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    tick_d    = tick_q;
    div_cnt_d = div_cnt_q;
    if (abort_s) begin
      state_d = IDLE;
    end else if (start_s) begin
      mode_d    = bus.data[1];
      tick_d    = '0;
      div_cnt_d = 8'h00;
      if (bus.data[1]) begin
        state_d = (duty_q >= target_q) ? DOWN : UP;
      end else if (duty_q < target_q) begin
        state_d = UP;
      end else if (duty_q > target_q) begin
        state_d = DOWN;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (state_q != IDLE) begin
      tick_d = tick_q + 1'b1;
      if (&tick_q) begin
        div_cnt_d = (div_cnt_q == div_q) ? 8'h00 : div_cnt_q + 8'h01;
      end else begin
        div_cnt_d = div_cnt_q;
      end
      if (!step_ev_s) begin
        state_d = state_q;
      end else if (!mode_q) begin
        duty_d = settle_duty_s;
        if (settle_duty_s == target_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = (duty_q < target_q) ? UP : DOWN;
        end
      end else if (state_q == UP) begin
        // Covers a TARGET lowered below duty: clamp to it and turn around
        if (up_sum_s >= target_q) begin
          duty_d  = target_q;
          state_d = DOWN;
        end else begin
          duty_d = up_sum_s;
        end
      end else begin
        duty_d = dn_diff_s;
        if (dn_diff_s == 8'h00) state_d = UP;
        else state_d = DOWN;
      end
    end else if (wr_s && (bus.addr == ADDR_DUTY)) begin
      duty_d = bus.data;
    end else begin
      duty_d = duty_q;
    end
    busy_d = (state_d != IDLE);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      duty_q    <= 8'h00;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= '0;
      div_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign duty_out = duty_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Scoreboard bench for pwm_fade_controller: every change of {duty,busy,done}
// is matched against an expected (cycle, value) entry queued by the stimulus.
module tb_pwm_fade_controller;

  logic       clk;
  logic       rst_n;
  logic [7:0] duty_out;
  logic       busy;
  logic       done;

  pwm_fade_controller_if bus_if ();

  pwm_fade_controller #(.PRESCALE_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if),
    .duty_out (duty_out),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    int         cyc;
    logic [7:0] duty;
    logic       busy;
    logic       done;
  } ev_t;

  ev_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  logic [9:0] prev_s = 10'h000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any visible change must match the head of the expected queue
  always @(negedge clk) begin
    logic [9:0] cur;
    ev_t e;
    if (mon_en) begin
      cur = {duty_out, busy, done};
      if (cur !== prev_s) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change cyc=%0d duty=%h busy=%b done=%b", cyc, duty_out, busy, done);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.duty !== duty_out || e.busy !== busy || e.done !== done) begin
            fails++;
            $display("FAIL event got cyc=%0d duty=%h busy=%b done=%b, want cyc=%0d duty=%h busy=%b done=%b",
                     cyc, duty_out, busy, done, e.cyc, e.duty, e.busy, e.done);
          end
        end
        prev_s = cur;
      end
    end
  end

  task automatic push(input int c, input logic [7:0] d, input logic b, input logic dn);
    ev_t e;
    e.cyc = c; e.duty = d; e.busy = b; e.done = dn;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d, output int c);
    @(negedge clk);
    bus_if.valid = 1'b1; bus_if.read_write = 1'b1; bus_if.addr = a; bus_if.data = d;
    @(posedge clk);
    #1;
    bus_if.valid = 1'b0; bus_if.read_write = 1'b0;
    c = cyc;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, act, exp_v);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_%s got=%0d pending want=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int c, c2;
    rst_n = 1'b0;
    bus_if.valid = 1'b0; bus_if.read_write = 1'b0; bus_if.addr = 7'h00; bus_if.data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_duty", duty_out, 8'h00);
    check("reset_busy", {7'h00, busy}, 8'h00);
    check("reset_done", {7'h00, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Up-ramp 0 -> 0x10, STEP 4, DIV 0
    wr(7'h06, 8'h04, c);
    wr(7'h05, 8'h10, c);
    wr(7'h08, 8'h01, c);
    push(c, 8'h00, 1'b1, 1'b0);
    push(c + 4, 8'h04, 1'b1, 1'b0);
    push(c + 8, 8'h08, 1'b1, 1'b0);
    push(c + 12, 8'h0C, 1'b1, 1'b0);
    push(c + 16, 8'h10, 1'b0, 1'b1);
    push(c + 17, 8'h10, 1'b0, 1'b0);
    drain("up");

    // Down-ramp with clamp, DIV 1
    wr(7'h04, 8'h20, c);
    push(c, 8'h20, 1'b0, 1'b0);
    wr(7'h05, 8'h05, c);
    wr(7'h06, 8'h10, c);
    wr(7'h07, 8'h01, c);
    wr(7'h08, 8'h01, c);
    push(c, 8'h20, 1'b1, 1'b0);
    push(c + 8, 8'h10, 1'b1, 1'b0);
    push(c + 16, 8'h05, 1'b0, 1'b1);
    push(c + 17, 8'h05, 1'b0, 1'b0);
    drain("down");
    wr(7'h07, 8'h00, c);

    // Saturation up to 0xFF and down to 0x00
    wr(7'h04, 8'h10, c);
    push(c, 8'h10, 1'b0, 1'b0);
    wr(7'h05, 8'hFF, c);
    wr(7'h06, 8'hFF, c);
    wr(7'h08, 8'h01, c);
    push(c, 8'h10, 1'b1, 1'b0);
    push(c + 4, 8'hFF, 1'b0, 1'b1);
    push(c + 5, 8'hFF, 1'b0, 1'b0);
    drain("sat_up");
    wr(7'h04, 8'h05, c);
    push(c, 8'h05, 1'b0, 1'b0);
    wr(7'h05, 8'h00, c);
    wr(7'h08, 8'h01, c);
    push(c, 8'h05, 1'b1, 1'b0);
    push(c + 4, 8'h00, 1'b0, 1'b1);
    push(c + 5, 8'h00, 1'b0, 1'b0);
    drain("sat_down");

    // Breathe 0..8 with STEP 4, then ABORT at duty 4
    wr(7'h05, 8'h08, c);
    wr(7'h06, 8'h04, c);
    wr(7'h08, 8'h03, c);
    push(c, 8'h00, 1'b1, 1'b0);
    push(c + 4, 8'h04, 1'b1, 1'b0);
    push(c + 8, 8'h08, 1'b1, 1'b0);
    push(c + 12, 8'h04, 1'b1, 1'b0);
    push(c + 16, 8'h00, 1'b1, 1'b0);
    push(c + 20, 8'h04, 1'b1, 1'b0);
    push(c + 24, 8'h08, 1'b1, 1'b0);
    push(c + 28, 8'h04, 1'b1, 1'b0);
    repeat (28) @(posedge clk);
    wr(7'h08, 8'h04, c2);
    push(c2, 8'h04, 1'b0, 1'b0);
    drain("breathe");
    check("abort_duty", duty_out, 8'h04);

    // START together with ABORT stays idle
    wr(7'h08, 8'h05, c);
    repeat (6) @(posedge clk);
    #1;
    check("start_abort_busy", {7'h00, busy}, 8'h00);
    check("start_abort_duty", duty_out, 8'h04);

    // DUTY write while busy is ignored
    wr(7'h08, 8'h01, c);
    push(c, 8'h04, 1'b1, 1'b0);
    push(c + 4, 8'h08, 1'b0, 1'b1);
    push(c + 5, 8'h08, 1'b0, 1'b0);
    wr(7'h04, 8'h77, c2);
    drain("duty_busy");

    // TARGET lowered mid up-ramp: next step heads down
    wr(7'h04, 8'h18, c);
    push(c, 8'h18, 1'b0, 1'b0);
    wr(7'h05, 8'h40, c);
    wr(7'h06, 8'h08, c);
    wr(7'h08, 8'h01, c);
    push(c, 8'h18, 1'b1, 1'b0);
    push(c + 4, 8'h20, 1'b1, 1'b0);
    push(c + 8, 8'h18, 1'b1, 1'b0);
    push(c + 12, 8'h10, 1'b0, 1'b1);
    push(c + 13, 8'h10, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    wr(7'h05, 8'h10, c2);
    drain("retarget");

    // START with duty == TARGET: immediate done
    wr(7'h08, 8'h01, c);
    push(c, 8'h10, 1'b0, 1'b1);
    push(c + 1, 8'h10, 1'b0, 1'b0);
    drain("equal");

    // Asynchronous reset mid-ramp
    wr(7'h05, 8'h40, c);
    wr(7'h08, 8'h01, c);
    push(c, 8'h10, 1'b1, 1'b0);
    push(c + 4, 8'h18, 1'b1, 1'b0);
    push(c + 5, 8'h00, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_duty", duty_out, 8'h00);
    check("async_rst_busy", {7'h00, busy}, 8'h00);
    check("async_rst_done", {7'h00, done}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drain("reset");

    // STEP back at its reset value of 1
    wr(7'h05, 8'h03, c);
    wr(7'h08, 8'h01, c);
    push(c, 8'h00, 1'b1, 1'b0);
    push(c + 4, 8'h01, 1'b1, 1'b0);
    push(c + 8, 8'h02, 1'b1, 1'b0);
    push(c + 12, 8'h03, 1'b0, 1'b1);
    push(c + 13, 8'h03, 1'b0, 1'b0);
    drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_fade_controller.md
# pwm_fade_controller

Autonomous duty-cycle sequencer for the PWM peripheral. It snoops the deserializer's write stream for its own configuration registers, then ramps an 8-bit duty value toward a target at a programmable rate. The duty value can either settle once or "breathe" continuously between 0 and the target. Its `duty_out` drives the PWM peripheral's `pwm_duty_cycle` input in place of a static register.

## Interface
- `PRESCALE_W`, default 8: base tick period is 2^PRESCALE_W clocks.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid` in 1: one-cycle strobe from the deserializer; a transaction is present.
- `read_write` in 1: 1 = write. Transactions with 0 are ignored.
- `addr` in 7: register address.
- `data` in 8: write data.
- `duty_out` out 8: current duty value to the PWM peripheral.
- `busy` out 1: high while a ramp is in progress (state != IDLE).
- `done` out 1: one-cycle pulse when a non-breathe ramp reaches its target.

## Operation
- A write is `valid && read_write`. Other addresses are ignored. Registers and their reset values:
  - 0x04 DUTY (direct load): loads `duty_out` only while IDLE; ignored while busy.
  - 0x05 TARGET, reset 0x00.
  - 0x06 STEP, reset 0x01. A value of 0 is treated as 1.
  - 0x07 DIV, reset 0x00. A step event occurs every (DIV+1) base ticks.
  - 0x08 CTRL, write-only strobes. bit0 START, bit1 BREATHE (latched as the mode at START), bit2 ABORT.
- Prescaler: a PRESCALE_W-bit tick counter plus an 8-bit divide counter.
  - Both counters clear on START.
  - Both counters hold while IDLE.
- States are IDLE, UP and DOWN. START from any state takes the transition below, using the current `duty_out` as the starting point.
- Non-breathe mode:
  - On START: if duty < TARGET, go to UP. If duty > TARGET, go to DOWN. If equal, pulse `done` and stay IDLE.
  - At each step event, direction is recomputed from the live TARGET. Mid-ramp TARGET writes are therefore honoured at the next step.
  - UP: duty = min(duty+STEP, TARGET).
  - DOWN: duty = max(duty−STEP, TARGET).
  - When duty equals TARGET, go to IDLE and pulse `done`.
- Breathe mode:
  - On START, go to UP. If duty ≥ TARGET, go to DOWN instead.
  - UP: duty = min(duty+STEP, TARGET). On reaching TARGET, switch to DOWN.
  - DOWN: duty = max(duty−STEP, 0). On reaching 0, switch to UP.
  - If TARGET drops below duty while in UP, the next step sets duty = TARGET and switches to DOWN.
  - `done` never pulses. Only ABORT ends a breathe ramp.
- ABORT: go to IDLE on the next clock. `duty_out` holds its current value and `done` does not pulse.
  - If START and ABORT are written together, ABORT wins.
- Arithmetic: the add and subtract use 9-bit intermediates and saturate at 0xFF and 0x00. `duty_out` must never wrap.

## Timing
- Reset values: `duty_out` = 0x00, `busy` = 0, `done` = 0, state = IDLE, counters = 0.
- Register writes take effect on the clock edge after the `valid` cycle.
- `busy` rises on the edge that captures START.
- First step: the step event fires on the clock edge (DIV+1)·2^PRESCALE_W cycles after the START-capture edge. Subsequent steps follow at the same interval.
- Each step updates `duty_out` on the step-event edge. `duty_out` is registered.
- `done` is asserted for exactly the cycle in which `duty_out` first shows the final value. `busy` falls on that same edge.
- Reset asserted mid-ramp returns all outputs to their reset values immediately (asynchronous).

## Test plan
- Up-ramp: PRESCALE_W=2, DIV=0, STEP=4, TARGET=0x10, START from duty 0.
  - `duty_out` steps 0x04, 0x08, 0x0C, 0x10 at 4, 8, 12 and 16 clocks after START capture.
  - `done` pulses once with 0x10. `busy` is low afterwards.
- Down-ramp with clamp: DUTY=0x20, TARGET=0x05, STEP=0x10, DIV=1.
  - `duty_out` goes 0x10 then 0x05, 8 clocks apart.
  - `done` pulses once.
- Saturation: DUTY=0x10, TARGET=0xFF, STEP=0xFF.
  - A single step to 0xFF with no wrap, then `done`.
  - Repeat DOWN from 0x05 with STEP=0xFF to TARGET=0, giving 0x00.
- Breathe: TARGET=0x08, STEP=4, BREATHE+START from 0.
  - `duty_out` sequence is 4, 8, 4, 0, 4, 8, …
  - `done` never pulses.
  - ABORT at duty 4 leaves the output at 4, with `busy` = 0.
- Collisions:
  - START and ABORT in the same write: stays IDLE.
  - A DUTY write while busy is ignored.
  - TARGET changed from 0x40 to 0x10 mid up-ramp at duty 0x20: the next step goes DOWN.
  - START with duty == TARGET: immediate `done`, no ramp.
- Reset mid-ramp: assert `rst_n`=0 asynchronously between clock edges.
  - `duty_out`, `busy` and `done` go to 0 before the next edge.
  - After release, STEP reads as 1 (verified by one ramp).
